// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension stage.
// An IN_W-bit immediate is widened to OUT_W bits (zero, sign, upper-half or
// word-offset) and held in a two-entry buffer: an output register plus a
// skid register. Because of the skid register, in_ready can come straight
// from a flop.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high on that side. A producer holds its data stable while valid
// is high and ready is low. The consumer sees out_data/out_neg held stable
// for as long as out_valid=1 and out_ready=0.
module imm_extend_pipe #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg,
    output logic [1:0]       dbg_state
);

    generate
        if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_params
            $error("imm_extend_pipe: need 1 <= IN_W < OUT_W");
        end
    endgenerate

    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_SIGN = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;

    // The state name is the number of results held in the buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] or_q, or_d;
    logic [OUT_W-1:0] sr_q, sr_d;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext;
    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;

    assign sign_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

    // Select the extended immediate for the current input mode.
    always_comb begin
        ext = '0;
        case (in_mode)
            MODE_ZERO: ext = {{PAD_W{1'b0}}, in_imm};
            MODE_SIGN: ext = sign_ext;
            MODE_HIGH: ext = {in_imm, {PAD_W{1'b0}}};
            MODE_WORD: ext = {sign_ext[OUT_W-2:0], 1'b0};
            default:   ext = '0;
        endcase
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    // Compute the next occupancy and decide which register takes new data.
    // A new result goes into OR only when OR is empty or is being drained
    // in the same cycle. Otherwise it goes into SR, and OR refills from SR
    // when it drains. This keeps results in strict FIFO order.
    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sr_d    = sr_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    or_d    = ext;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    or_d    = ext;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    sr_d    = ext;
                    state_d = ST_TWO;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    or_d    = sr_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Hold state and data. in_ready is registered from the next state, so
    // out_ready never reaches in_ready through combinational logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            or_q       <= '0;
            sr_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            or_q       <= or_d;
            sr_q       <= sr_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = or_q;
    assign out_neg   = or_q[OUT_W-1];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe. The behavioural model is a queue of expected
// results, computed with integer arithmetic from the extension rules. A
// second instance covers the wide parameter set.
module tb_imm_extend_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (5 -> 16) ----------------
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_neg;
  logic [1:0]  dbg_state;

  imm_extend_pipe #(.IN_W(5), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (12 -> 32) ----------------
  logic        v32;
  logic        ir32;
  logic [11:0] imm32;
  logic [1:0]  mode32;
  logic        ov32;
  logic        rdy32;
  logic [31:0] od32;
  logic        on32;
  logic [1:0]  dbg32;

  imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(ir32), .in_imm(imm32), .in_mode(mode32),
    .out_valid(ov32), .out_ready(rdy32), .out_data(od32), .out_neg(on32),
    .dbg_state(dbg32)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension, computed from the mode rules with integer arithmetic.
  function automatic logic [63:0] model_ext(input int iw, input int ow,
                                            input longint imm, input logic [1:0] mode);
    longint s;
    longint r;
    longint mask;
    mask = (longint'(1) << ow) - 1;
    s = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
    case (mode)
      2'd0:    r = imm;
      2'd1:    r = s;
      2'd2:    r = imm * (longint'(1) << (ow - iw));
      default: r = s * 2;
    endcase
    return 64'(r & mask);
  endfunction

  // ---------------- compare process ----------------
  // Runs at the falling edge, where inputs and DUT outputs are both settled.
  // The model occupancy is the size of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(exp_q[0]));
        check("out_neg", 64'(out_neg), 64'(exp_q[0][15]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(16'(model_ext(5, 16, longint'(in_imm), in_mode)));
    end
  end

  // ---------------- driver tasks ----------------
  // Hold the current input until it is accepted. Gives up after a bounded
  // number of cycles.
  task automatic wait_accept(input string name);
    logic acc;
    int   k;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: input not accepted within 50 cycles", name);
    end
  endtask

  // Send one item into an empty stage with out_ready=1 and check the result
  // one cycle later against a hand-computed literal.
  task automatic directed(input string name, input logic [4:0] imm, input logic [1:0] mode,
                          input logic [15:0] exp_d, input logic exp_n);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_data"}, 64'(out_data), 64'(exp_d));
    check({name, "_neg"}, 64'(out_neg), 64'(exp_n));
    @(posedge clk);
    #1;
  endtask

  task automatic directed32(input string name, input logic [11:0] imm, input logic [1:0] mode,
                            input logic [31:0] exp_d);
    v32    = 1'b1;
    imm32  = imm;
    mode32 = mode;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(ov32), 64'(1));
    check({name, "_data"}, 64'(od32), 64'(exp_d));
    check({name, "_neg"}, 64'(on32), 64'(exp_d[31]));
    @(posedge clk);
    #1;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    v32       = 1'b0;
    imm32     = '0;
    mode32    = '0;
    rdy32     = 1'b1;
    #11;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_neg", 64'(out_neg), 64'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model itself to hand-computed values.
    check("model_zero", model_ext(5, 16, 22, 2'd0), 64'h0016);
    check("model_sign", model_ext(5, 16, 22, 2'd1), 64'hFFF6);
    check("model_high", model_ext(5, 16, 22, 2'd2), 64'hB000);
    check("model_word", model_ext(5, 16, 22, 2'd3), 64'hFFEC);
    check("model_w32", model_ext(12, 32, 64'h800, 2'd3), 64'hFFFFF000);

    // Each mode on a negative immediate, then on a positive one.
    directed("zero_neg", 5'b10110, 2'd0, 16'h0016, 1'b0);
    directed("sign_neg", 5'b10110, 2'd1, 16'hFFF6, 1'b1);
    directed("high_neg", 5'b10110, 2'd2, 16'hB000, 1'b1);
    directed("word_neg", 5'b10110, 2'd3, 16'hFFEC, 1'b1);
    directed("sign_pos", 5'b01111, 2'd1, 16'h000F, 1'b0);
    directed("word_pos", 5'b01111, 2'd3, 16'h001E, 1'b0);
    directed("high_pos", 5'b01111, 2'd2, 16'h7800, 1'b0);

    // Backpressure: A and B fill the buffer and C has to wait.
    base = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 5'd3;  in_mode = 2'd1;
    @(posedge clk); #1;
    in_imm    = 5'd17; in_mode = 2'd3;
    @(posedge clk); #1;
    in_imm    = 5'd9;  in_mode = 2'd2;
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept("bp_c_accept");
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", 64'(n_out - base), 64'(3));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Streaming: 20 back-to-back random items with out_ready held high.
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_imm   = 5'($urandom_range(0, 31));
      in_mode  = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_count", 64'(n_out - base), 64'(20));

    // Random traffic with random backpressure on both sides.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_imm    = 5'($urandom_range(0, 31));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("random_drained", 64'(exp_q.size()), 64'(0));

    // Reset while the buffer holds two entries.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 5'd21; in_mode = 2'd1;
    @(posedge clk); #1;
    in_imm    = 5'd6;  in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    base = n_out;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_output", 64'(n_out - base), 64'(0));

    // Wide parameter set.
    directed32("w32_sign", 12'h800, 2'd1, 32'hFFFFF800);
    directed32("w32_high", 12'h800, 2'd2, 32'h80000000);
    directed32("w32_word", 12'h800, 2'd3, 32'hFFFFF000);
    directed32("w32_zero", 12'h800, 2'd0, 32'h00000800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
